fc_requant_serializer: RTL and testbench
========================================

# fc_requant_serializer

Downstream companion to the fully connected input layer. It captures the parallel vector of `NUM_NEURONS` accumulator results on a single-cycle valid pulse. Each element is requantized (arithmetic right shift, ReLU, saturation to `DATA_WIDTH`), buffered, and replayed one element per accepted beat as a serial activation stream with ready/valid backpressure. The result is the `data_in`/`in_valid` stream for the next FC layer.

## Interface
Parameters:
- `NUM_NEURONS`, 8: vector length; number of elements captured and serialized.
- `ACC_WIDTH`, 32: width of each signed input accumulator element.
- `DATA_WIDTH`, 8: width of the signed output activation.
- `SHIFT`, 8: requantization right-shift amount, 1 ≤ `SHIFT` < `ACC_WIDTH`.

Ports:
- `clk`, in, 1: the block's one clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `in_valid`, in, 1: one-cycle pulse; `in_data` holds a complete vector.
- `in_data[NUM_NEURONS]`, in, signed `ACC_WIDTH` each: accumulator vector, biased.
- `out_valid`, out, 1: `out_data` holds a valid activation.
- `out_ready`, in, 1: consumer accepts the current element.
- `out_data`, out, signed `DATA_WIDTH`: requantized activation.
- `out_last`, out, 1: high with the element at index `NUM_NEURONS-1`.
- `busy`, out, 1: a vector is held or being serialized.
- `overflow`, out, 1: sticky; a vector arrived while the block could not accept it.
- `overflow_clr`, in, 1: clears `overflow`.

## Operation
- FSM, two states:
  - IDLE: `busy`=0, `out_valid`=0.
  - SEND: `busy`=1, `out_valid`=1.
- IDLE → SEND on `in_valid`.
  - All `NUM_NEURONS` requantized elements are written to the buffer.
  - Index is set to 0.
- In SEND, `out_data` = buf[idx] and `out_last` = (idx == `NUM_NEURONS-1`).
- A handshake (`out_valid` && `out_ready`) advances idx.
- A handshake at idx == `NUM_NEURONS-1` takes SEND → IDLE.
  - If `in_valid` is high in that same cycle, the new vector is captured instead and the state stays SEND with idx=0. This gives back-to-back vectors with no bubble.
- `in_valid` in SEND without a final handshake in that cycle:
  - The vector is dropped and `overflow` is set.
  - The buffer and idx are unchanged.
- `overflow_clr` and a new overflow in the same cycle: `overflow` ends at 1 (set wins).
- Requantization, per element, combinational at capture:
  - x = `in_data` sign-extended to `ACC_WIDTH+1` bits.
  - Optional rounding add (see Configuration).
  - y = x >>> `SHIFT`.
  - If y < 0, result is 0 (ReLU).
  - Else if y > 2^(`DATA_WIDTH`-1)-1, result is saturated to that value.
  - Else result is y.
  - The output range is therefore 0 to 2^(`DATA_WIDTH`-1)-1.
- `out_data` is 0 whenever `out_valid` is 0.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` stay stable.

## Timing
- Reset values: FSM in IDLE, idx 0, buffer 0, `out_valid` 0, `out_data` 0, `out_last` 0, `busy` 0, `overflow` 0.
- Reset mid-SEND aborts the vector immediately. No partial vector resumes.
- Latency:
  - `in_valid` sampled at edge N gives `out_valid`=1 with element 0 after edge N.
  - With `out_ready` held high, element k appears in cycle N+1+k.
  - The vector completes in exactly `NUM_NEURONS` cycles.
- Throughput is one element per cycle with `out_ready`=1. A new vector can be accepted every `NUM_NEURONS` cycles.
- `out_valid` never drops without a handshake; there is no retraction.
- `out_ready` is not required to be stable. The block has no combinational path from `out_ready` to `out_valid`.

## Configuration
- Macro `FC_REQUANT_ROUND_EN`.
- Defined: 2^(`SHIFT`-1) is added to x before the shift (round half up), in the `ACC_WIDTH+1`-bit domain, so it never wraps.
- Undefined: plain truncation toward −∞ by arithmetic shift. No adder is instantiated.

## Structure
- Shared package `fc_pkg`:
  - FSM state enum `fc_ser_state_t` (IDLE, SEND).
  - Function computing the saturation limit from `DATA_WIDTH`.
  - Index width `$clog2(NUM_NEURONS)`.
- Sub-module `fc_requant`: purely combinational, one element (shift, optional round, ReLU, saturate). It is instantiated `NUM_NEURONS` times in a generate loop. The top level holds the FSM, buffer, index counter and overflow flag.

## Test plan
All cases use the default parameters.
- Basic truncation, rounding off, `out_ready`=1:
  - `in_data` = {256, 512, −300, 40000, 383, 0, 128, 127}.
  - Output stream is 1, 2, 0, 127, 1, 0, 0, 0 in cycles N+1 to N+8.
  - `out_last` is high only on the 8th element.
- Same vector with `FC_REQUANT_ROUND_EN` defined:
  - Output stream is 1, 2, 0, 127, 1, 0, 1, 0.
- Backpressure:
  - `out_ready` toggles 1,0,0,1,… randomly.
  - Each element is held stable while stalled.
  - All 8 elements arrive in order; `busy` drops after the final handshake.
- Overflow:
  - A second `in_valid` arrives 3 cycles after the first.
  - Result: `overflow`=1, and the first vector streams intact.
  - `overflow_clr` returns `overflow` to 0.
- Back-to-back:
  - `in_valid` arrives coincident with the final handshake.
  - Result: 16 consecutive `out_valid` cycles, `overflow` stays 0, `out_last` at elements 8 and 16.
- Asynchronous reset asserted mid-vector at element 4:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, a fresh vector streams from element 0.

Source files
------------

// File: rtl/fc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fc_pkg : shared types and helpers for the FC requantizing serializer.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package fc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } fc_ser_state_t;

  // Largest positive value representable in a signed DATA_WIDTH activation.
  function automatic int sat_limit(input int data_width);
    return (1 << (data_width - 1)) - 1;
  endfunction

  function automatic int idx_width(input int num_neurons);
    return (num_neurons > 1) ? $clog2(num_neurons) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fc_requant.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fc_requant : one-element requantizer (shift, optional round, ReLU, sat). |
// | Option macro: FC_REQUANT_ROUND_EN (round half up before the shift).      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fc_requant
  import fc_pkg::*;
#(
  parameter int ACC_WIDTH  = 32,
  parameter int DATA_WIDTH = 8,
  parameter int SHIFT      = 8
) (
  input  logic signed [ACC_WIDTH-1:0]  acc_in,
  output logic signed [DATA_WIDTH-1:0] act_out
);

  localparam logic signed [ACC_WIDTH:0] c_limit = (ACC_WIDTH+1)'(sat_limit(DATA_WIDTH));

  logic signed [ACC_WIDTH:0] x_ext;
  logic signed [ACC_WIDTH:0] x_adj;
  logic signed [ACC_WIDTH:0] y_shr;

  // One guard bit keeps the rounding add from ever wrapping.
  assign x_ext = {acc_in[ACC_WIDTH-1], acc_in};

`ifdef FC_REQUANT_ROUND_EN
  localparam logic signed [ACC_WIDTH:0] c_round = (ACC_WIDTH+1)'(1) << (SHIFT - 1);
  assign x_adj = x_ext + c_round;
`else
  assign x_adj = x_ext;
`endif

  assign y_shr = x_adj >>> SHIFT;

  always_comb begin
    act_out = '0;
    if (y_shr[ACC_WIDTH]) begin
      act_out = '0;
    end else if (y_shr > c_limit) begin
      act_out = c_limit[DATA_WIDTH-1:0];
    end else begin
      act_out = y_shr[DATA_WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fc_requant_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fc_requant_serializer : captures an accumulator vector, requantizes it   |
// | and replays it as a ready/valid activation stream.                       |
// | Option macro: FC_REQUANT_ROUND_EN (passed through to fc_requant).        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fc_requant_serializer
  import fc_pkg::*;
#(
  parameter int NUM_NEURONS = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT       = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic signed [ACC_WIDTH-1:0]  in_data [NUM_NEURONS],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         overflow,
  input  logic                         overflow_clr
);

  localparam int IDX_W = idx_width(NUM_NEURONS);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_NEURONS - 1);

  fc_ser_state_t               state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0] buf_q [NUM_NEURONS];
  logic signed [DATA_WIDTH-1:0] buf_d [NUM_NEURONS];
  logic                        overflow_q, overflow_d;

  logic signed [DATA_WIDTH-1:0] req [NUM_NEURONS];
  logic                        hs;
  logic                        final_hs;
  logic                        ovf_set;

  for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_requant
    fc_requant #(
      .ACC_WIDTH (ACC_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .SHIFT     (SHIFT)
    ) u_requant (
      .acc_in (in_data[i]),
      .act_out(req[i])
    );
  end

  // Outputs depend only on flops, so reset clears them without a clock edge.
  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_last  = out_valid && (idx_q == c_last_idx);
  assign out_data  = out_valid ? buf_q[idx_q] : '0;
  assign overflow  = overflow_q;

  assign hs       = out_valid && out_ready;
  assign final_hs = hs && (idx_q == c_last_idx);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    ovf_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SEND;
          idx_d   = '0;
          buf_d   = req;
        end
      end
      SEND: begin
        if (final_hs) begin
          idx_d = '0;
          // A vector arriving on the final beat chains on with no bubble.
          if (in_valid) begin
            buf_d = req;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (hs) begin
            idx_d = idx_q + IDX_W'(1);
          end
          if (in_valid) begin
            ovf_set = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    overflow_d = ovf_set | (overflow_q & ~overflow_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      buf_q      <= '{default: '0};
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fc_requant_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fc_requant_serializer : self-checking bench with a queue-based model. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_fc_requant_serializer;

  localparam int NN = 8;
  localparam int AW = 32;
  localparam int DW = 8;
  localparam int SH = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic signed [AW-1:0] in_data [NN];
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_last;
  logic                 busy;
  logic                 overflow;
  logic                 overflow_clr;

  fc_requant_serializer #(
    .NUM_NEURONS(NN),
    .ACC_WIDTH  (AW),
    .DATA_WIDTH (DW),
    .SHIFT      (SH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_val[$];
  bit exp_last[$];
  bit ovf_model;

  logic signed [AW-1:0] vec_a [NN];
  logic signed [AW-1:0] vec_b [NN];

  // Reference requantization done in wide integer arithmetic.
  function automatic int model_rq(input longint acc);
    longint x;
    longint y;
    longint lim;
    x = acc;
`ifdef FC_REQUANT_ROUND_EN
    x = x + (64'sd1 <<< (SH - 1));
`endif
    y   = x >>> SH;
    lim = (64'sd1 <<< (DW - 1)) - 1;
    if (y < 0) return 0;
    if (y > lim) return int'(lim);
    return int'(y);
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_vec(input logic signed [AW-1:0] v [NN]);
    for (int i = 0; i < NN; i++) begin
      exp_val.push_back(model_rq(longint'(v[i])));
      exp_last.push_back(i == NN - 1);
    end
  endtask

  task automatic rand_vec(output logic signed [AW-1:0] v [NN]);
    for (int i = 0; i < NN; i++) begin
      if (i % 2 == 0) v[i] = $signed($urandom);
      else            v[i] = $signed($urandom_range(0, 70000)) - 20000;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"},  out_data,  0);
    chk({tag, "_last"},  out_last,  0);
    chk({tag, "_busy"},  busy,      0);
  endtask

  // Called at a negedge while the DUT is idle; leaves us at the next negedge.
  task automatic start_vec(input logic signed [AW-1:0] v [NN]);
    in_data  = v;
    in_valid = 1'b1;
    push_vec(v);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Consumes the expected stream; optionally injects vector inj_v at cycle inj_cycle.
  task automatic drain(input bit rnd, input int inj_cycle, input logic signed [AW-1:0] inj_v [NN]);
    int  cyc;
    bit  accept;
    cyc = 0;
    while (exp_val.size() > 0 && cyc < 300) begin
      chk("stream_valid", out_valid, 1);
      chk("stream_data",  out_data,  exp_val[0]);
      chk("stream_last",  out_last,  exp_last[0]);
      chk("stream_busy",  busy,      1);
      chk("stream_ovf",   overflow,  ovf_model);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      accept = 1'b0;
      if (cyc == inj_cycle) begin
        in_valid = 1'b1;
        in_data  = inj_v;
        if (out_ready && exp_last[0]) accept = 1'b1;
        else                          ovf_model = 1'b1;
      end
      if (out_ready) begin
        void'(exp_val.pop_front());
        void'(exp_last.pop_front());
      end
      if (accept) push_vec(inj_v);
      @(negedge clk);
      in_valid = 1'b0;
      cyc++;
    end
    chk("drain_done", exp_val.size(), 0);
    check_idle("after_drain");
    chk("after_drain_ovf", overflow, ovf_model);
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    overflow_clr = 1'b0;
    ovf_model    = 1'b0;
    in_data      = '{default: '0};
    repeat (2) @(negedge clk);
    check_idle("reset");
    chk("reset_ovf", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector with ReLU, saturation and rounding-sensitive values.
    vec_a = '{256, 512, -300, 40000, 383, 0, 128, 127};
    start_vec(vec_a);
    drain(1'b0, -1, vec_a);

    // Random data under random backpressure.
    for (int r = 0; r < 3; r++) begin
      rand_vec(vec_a);
      start_vec(vec_a);
      drain(1'b1, -1, vec_a);
    end

    // Second vector mid-stream is dropped and flagged.
    rand_vec(vec_a);
    rand_vec(vec_b);
    start_vec(vec_a);
    drain(1'b0, 3, vec_b);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    ovf_model    = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Drop during backpressure, then clear coincident with a new drop: set wins.
    rand_vec(vec_a);
    start_vec(vec_a);
    out_ready    = 1'b0;
    in_valid     = 1'b1;
    in_data      = vec_b;
    overflow_clr = 1'b1;
    @(negedge clk);
    in_valid     = 1'b0;
    overflow_clr = 1'b0;
    ovf_model    = 1'b1;
    chk("ovf_set_wins", overflow, 1);
    drain(1'b1, -1, vec_b);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    ovf_model    = 1'b0;

    // Back-to-back: second vector arrives on the final handshake.
    rand_vec(vec_a);
    rand_vec(vec_b);
    start_vec(vec_a);
    drain(1'b0, NN - 1, vec_b);

    // Asynchronous reset while element 4 is presented.
    rand_vec(vec_a);
    start_vec(vec_a);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("pre_rst_data", out_data, exp_val[0]);
      void'(exp_val.pop_front());
      void'(exp_last.pop_front());
      @(negedge clk);
    end
    chk("pre_rst_elem4", out_data, exp_val[0]);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    chk("async_rst_ovf", overflow, 0);
    exp_val.delete();
    exp_last.delete();
    ovf_model = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");
    rand_vec(vec_a);
    start_vec(vec_a);
    drain(1'b1, -1, vec_a);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
